// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg: EX->MEM pipeline register with valid/ready handshakes on both sides.
// Latency: one cycle from accept into an empty stage to out_valid_o.
// Backpressure: with EXMEM_SKID_EN a skid entry absorbs one extra beat and in_ready_o is
//   registered; without it, in_ready_o = !out_valid_o || out_ready_i (combinational).
// Build option: define EXMEM_SKID_EN to add the skid entry and the registered in_ready_o.
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i          : clock, reset, pipeline flush
//   in_valid_i / in_ready_o                             : upstream (EX) handshake
//   ctrl_i, alu_result_i, pc_plus_branch_i, reg_data2_i,
//   r_dest_selected_i, jump_left_shifted_two_i          : incoming entry fields
//   out_valid_o / out_ready_i                           : downstream (MEM) handshake
//   ctrl_o, alu_result_o, ... jump_left_shifted_two_o   : registered entry fields
//   stall_count_o                                       : saturating count of stalled cycles
module ex_mem_stage_reg #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int JUMP_W  = 28,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [12:0]        ctrl_i,
    input  logic [DATA_W-1:0]  alu_result_i,
    input  logic [DATA_W-1:0]  pc_plus_branch_i,
    input  logic [DATA_W-1:0]  reg_data2_i,
    input  logic [RADDR_W-1:0] r_dest_selected_i,
    input  logic [JUMP_W-1:0]  jump_left_shifted_two_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [12:0]        ctrl_o,
    output logic [DATA_W-1:0]  alu_result_o,
    output logic [DATA_W-1:0]  pc_plus_branch_o,
    output logic [DATA_W-1:0]  reg_data2_o,
    output logic [RADDR_W-1:0] r_dest_selected_o,
    output logic [JUMP_W-1:0]  jump_left_shifted_two_o,
    output logic [CNT_W-1:0]   stall_count_o
);

    // ctrl layout, MSB first: R_Enable, W_Enable, RegWrite, MemToReg, Zero,
    // BranchSel[3:0], R_Width[1:0], W_Width[1:0]. These bits must read 0 in a bubble
    // so a stale entry can never trigger a memory access, register write or branch.
    localparam logic [12:0] BUBBLE_MASK = 13'b1_1100_1111_0000;
    localparam logic [CNT_W-1:0] STALL_MAX = '1;

    typedef struct packed {
        logic [12:0]        ctrl;
        logic [DATA_W-1:0]  alu;
        logic [DATA_W-1:0]  pcb;
        logic [DATA_W-1:0]  rd2;
        logic [RADDR_W-1:0] rdest;
        logic [JUMP_W-1:0]  jump;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_MAIN  = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    entry_t           main_q, main_d;
    entry_t           in_entry;
    logic             out_valid;
    logic             accept;
    logic             consume;
    logic [CNT_W-1:0] stall_q;

    assign in_entry  = '{ctrl: ctrl_i, alu: alu_result_i, pcb: pc_plus_branch_i,
                         rd2: reg_data2_i, rdest: r_dest_selected_i,
                         jump: jump_left_shifted_two_i};
    assign out_valid = (state_q != S_EMPTY);
    assign accept    = in_valid_i && in_ready_o;
    assign consume   = out_valid && out_ready_i;

`ifdef EXMEM_SKID_EN
    entry_t skid_q, skid_d;
    logic   in_ready_q;
    // Registered ready keeps out_ready_i off the upstream timing path; the skid
    // entry catches the one beat that arrives after downstream stalls.
    assign in_ready_o = in_ready_q;
`else
    assign in_ready_o = !out_valid || out_ready_i;
`endif

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef EXMEM_SKID_EN
        skid_d  = skid_q;
`endif
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    main_d  = in_entry;
                    state_d = S_MAIN;
                end
            end
            S_MAIN: begin
                if (consume && accept) begin
                    main_d = in_entry;
                end else if (consume) begin
                    state_d = S_EMPTY;
`ifdef EXMEM_SKID_EN
                end else if (accept) begin
                    skid_d  = in_entry;
                    state_d = S_FULL;
`endif
                end
            end
`ifdef EXMEM_SKID_EN
            S_FULL: begin
                // in_ready_o is 0 here, so only a consume can move things along.
                if (consume) begin
                    main_d  = skid_q;
                    state_d = S_MAIN;
                end
            end
`endif
            default: state_d = S_EMPTY;
        endcase
        // Flush discards held and incoming entries regardless of handshakes.
        if (flush_i) begin
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
`ifdef EXMEM_SKID_EN
            skid_q     <= '0;
            in_ready_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
`ifdef EXMEM_SKID_EN
            skid_q     <= skid_d;
            in_ready_q <= (state_d != S_FULL);
`endif
        end
    end

    // Stall counter saturates and survives flush; only reset clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready_i && (stall_q != STALL_MAX)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign out_valid_o             = out_valid;
    assign ctrl_o                  = out_valid ? main_q.ctrl : (main_q.ctrl & ~BUBBLE_MASK);
    assign alu_result_o            = main_q.alu;
    assign pc_plus_branch_o        = main_q.pcb;
    assign reg_data2_o             = main_q.rd2;
    assign r_dest_selected_o       = main_q.rdest;
    assign jump_left_shifted_two_o = main_q.jump;
    assign stall_count_o           = stall_q;

endmodule

// File: doc/ex_mem_stage_reg.md
EX_MEM_STAGE_REG -- requirements
Module: ex_mem_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of ALUResult, PCPlusBranch, RegData2.
REQ-002 Parameter RADDR_W, default 5: width of rDestSelected.
REQ-003 Parameter JUMP_W, default 28: width of jumpLeftShiftedTwo.
REQ-004 Parameter CNT_W, default 16: width of StallCount.
REQ-005 Clock  in  1: single clock, all state updates on posedge.
REQ-006 Reset  in  1: synchronous, active-high reset.
REQ-007 Flush  in  1: discard all held and incoming entries.
REQ-008 InValid  in  1 / InReady  out  1: upstream (EX) handshake.
REQ-009 CtrlIn  in  13: packed {R_Enable, W_Enable, RegWrite, MemToReg, Zero, BranchSel[3:0], R_Width[1:0], W_Width[1:0]}, MSB first.
REQ-010 ALUResultIn, PCPlusBranchIn, RegData2In  in  DATA_W each; rDestSelectedIn  in  RADDR_W; jumpLeftShiftedTwoIn  in  JUMP_W.
REQ-011 OutValid  out  1 / OutReady  in  1: downstream (MEM) handshake.
REQ-012 CtrlOut  out  13, ALUResultOut, PCPlusBranchOut, RegData2Out  out  DATA_W, rDestSelectedOut  out  RADDR_W, jumpLeftShiftedTwoOut  out  JUMP_W: registered copies of the accepted entry.
REQ-013 StallCount  out  CNT_W: cycles with OutValid=1 and OutReady=0.

Function
REQ-014 An entry SHALL be accepted on a posedge when InValid=1 and InReady=1, and consumed when OutValid=1 and OutReady=1.
REQ-015 Latency SHALL be one cycle: an entry accepted into an empty block appears on the outputs with OutValid=1 in the next cycle.
REQ-016 Storage SHALL be a main entry plus a skid entry; states EMPTY (none valid), MAIN (main valid), FULL (main+skid valid).
REQ-017 Transitions: EMPTY->MAIN on accept; MAIN->EMPTY on consume without accept; MAIN->MAIN on consume and accept (main replaced); MAIN->FULL on accept without consume (input to skid); FULL->MAIN on consume (skid moves to main); all other cases hold.
REQ-018 InReady SHALL be a registered signal equal to 1 in EMPTY and MAIN, 0 in FULL; no combinational path from OutReady to InReady.
REQ-019 Entries SHALL leave in acceptance order; no entry dropped or duplicated except by Flush/Reset.
REQ-020 Flush=1 SHALL force next state EMPTY, discarding main, skid and any same-cycle input, taking priority over accept and consume.
REQ-021 When OutValid=0, CtrlOut bits R_Enable, W_Enable, RegWrite and BranchSel SHALL read 0 (bubble safe); other output fields are don't-care.
REQ-022 StallCount SHALL increment by 1 each cycle with OutValid=1 and OutReady=0, saturate at 2^CNT_W-1, and not clear on Flush.
REQ-023 Held output fields SHALL remain stable while OutValid=1 and OutReady=0.

Reset
REQ-024 Reset=1 on a posedge SHALL force state EMPTY, OutValid=0, InReady=1, StallCount=0, all data/control outputs 0, overriding Flush and handshakes.
REQ-025 Reset asserted mid-operation SHALL discard all entries; first accept after deassertion follows REQ-015.

Configuration
REQ-026 Macro EXMEM_SKID_EN: when defined, the skid entry and registered InReady of REQ-016-REQ-018 SHALL be built.
REQ-027 When EXMEM_SKID_EN is undefined, only the main entry SHALL exist (states EMPTY, MAIN) and InReady SHALL equal (!OutValid || OutReady) combinationally; all other requirements unchanged.

Verification
REQ-028 Reset, then InValid=1, ALUResultIn=0x0000_1234, OutReady=1 -> next cycle OutValid=1, ALUResultOut=0x0000_1234; following cycle OutValid=0 if InValid=0.
REQ-029 OutReady=0, accept A=0x11 then B=0x22 -> InReady=0 after B; A held on outputs; OutReady=1 -> A then B delivered in consecutive cycles, InReady returns 1.
REQ-030 Back-to-back stream 0x1..0x8 with OutReady=1 continuous -> one entry per cycle, order 0x1..0x8, InReady stays 1.
REQ-031 FULL state with InValid=1 and Flush=1 -> next cycle OutValid=0, InReady=1, CtrlOut W_Enable=RegWrite=0, input discarded.
REQ-032 OutValid=1, OutReady=0 for 5 cycles with CNT_W=2 -> StallCount reads 1,2,3,3,3; Reset -> 0.
REQ-033 Build without EXMEM_SKID_EN, OutValid=1, OutReady toggled 0/1 -> InReady tracks OutReady same cycle; no entry lost.
